// File: rtl/rdback_c2h_packetizer.sv
// rdback_c2h_packetizer: buffers HBM read beats in a FIFO and
// frames them into C2H AXI-stream packets (fixed length or flush).
module rdback_c2h_packetizer #(
  parameter int DATA_WIDTH = 512,
  parameter int FIFO_DEPTH = 64,
  parameter int PKT_BEATS  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_valid,
  input  logic                    flush,
  output logic [11:0]             buffer_space,
  output logic [DATA_WIDTH-1:0]   c2h_tdata,
  output logic [DATA_WIDTH/8-1:0] c2h_tkeep,
  output logic                    c2h_tlast,
  output logic                    c2h_tvalid,
  input  logic                    c2h_tready,
  output logic                    overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam int CW = $clog2(PKT_BEATS);
  localparam logic [CW-1:0] LAST_CNT = CW'(PKT_BEATS - 1);
  localparam logic [OW-1:0] ONE = OW'(1);

  typedef enum logic {STREAM, PAD} state_t;

  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [OW-1:0] wr_ptr, rd_ptr, occ, occ_nx;
  logic [OW-1:0] cnt_f, fc_eff, flush_cnt;
  logic [CW-1:0] pkt_cnt;
  logic full, empty, push, pop;
  logic load_ok, hs, ld_last;
  logic pad_loaded, pad_ld, pad_done;

  assign occ     = wr_ptr - rd_ptr;
  assign full    = occ[AW];
  assign empty   = (occ == '0);
  assign push    = rd_valid && !full;
  assign load_ok = !c2h_tvalid || c2h_tready;
  assign hs      = c2h_tvalid && c2h_tready;
  assign cnt_f   = occ + OW'(push);
  assign fc_eff  = flush ? cnt_f : flush_cnt;
  assign pop     = (state == STREAM) && load_ok && !empty;
  assign pad_ld  = (state == PAD) && !pad_loaded && load_ok;
  assign pad_done = (state == PAD) && pad_loaded && hs;
  assign ld_last = (pkt_cnt == LAST_CNT) || (fc_eff == ONE);
  assign occ_nx  = occ + OW'(push) - OW'(pop);
  assign c2h_tkeep = '1;

  // FIFO storage, no reset needed on the array
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rd_data;
  end

  // FIFO pointers, space report and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      buffer_space <= 12'(FIFO_DEPTH);
      overflow     <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + OW'(push);
      rd_ptr       <= rd_ptr + OW'(pop);
      buffer_space <= 12'(FIFO_DEPTH) - 12'(occ_nx);
      if (rd_valid && full) overflow <= 1'b1;
    end
  end

  // state register and pad-beat tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STREAM;
      pad_loaded <= 1'b0;
    end else begin
      state <= state_nx;
      if (pad_done)    pad_loaded <= 1'b0;
      else if (pad_ld) pad_loaded <= 1'b1;
    end
  end

  // next state: open packet with nothing left to carry tlast needs a pad
  always_comb begin
    state_nx = state;
    unique case (state)
      STREAM: begin
        if (flush && cnt_f == '0 && pkt_cnt != '0)
          state_nx = PAD;
      end
      PAD: begin
        if (pad_done) state_nx = STREAM;
      end
      default: state_nx = STREAM;
    endcase
  end

  // AXIS output register, frozen while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c2h_tvalid <= 1'b0;
      c2h_tlast  <= 1'b0;
      c2h_tdata  <= '0;
    end else if (pad_ld) begin
      c2h_tvalid <= 1'b1;
      c2h_tlast  <= 1'b1;
      c2h_tdata  <= '0;
    end else if (pop) begin
      c2h_tvalid <= 1'b1;
      c2h_tlast  <= ld_last;
      c2h_tdata  <= mem[rd_ptr[AW-1:0]];
    end else if (hs) begin
      c2h_tvalid <= 1'b0;
    end
  end

  // packet beat count and beats owed to the last flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      if (pad_done)
        pkt_cnt <= '0;
      else if (pop)
        pkt_cnt <= ld_last ? '0 : pkt_cnt + CW'(1);
      if (pop && ld_last)
        flush_cnt <= '0;
      else if (flush)
        flush_cnt <= cnt_f - OW'(pop);
      else if (pop && flush_cnt != '0)
        flush_cnt <= flush_cnt - ONE;
    end
  end

endmodule

// File: tb/tb_rdback_c2h_packetizer.sv
// tb_rdback_c2h_packetizer: random and directed stimulus against a
// queue-based reference model with a decoupled scoreboard monitor.
module tb_rdback_c2h_packetizer;
  localparam int DW    = 512;
  localparam int DEPTH = 64;
  localparam int PKT   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic rd_valid = 1'b0;
  logic flush = 1'b0;
  logic c2h_tready = 1'b0;
  logic [11:0] buffer_space;
  logic [DW-1:0] c2h_tdata;
  logic [DW/8-1:0] c2h_tkeep;
  logic c2h_tlast, c2h_tvalid, overflow;

  int vecs = 0;
  int errs = 0;

  rdback_c2h_packetizer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .PKT_BEATS (PKT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .flush       (flush),
    .buffer_space(buffer_space),
    .c2h_tdata   (c2h_tdata),
    .c2h_tkeep   (c2h_tkeep),
    .c2h_tlast   (c2h_tlast),
    .c2h_tvalid  (c2h_tvalid),
    .c2h_tready  (c2h_tready),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // entry: data plus a flag (flush tag in the buffer, tlast in scoreboard)
  typedef struct packed {
    logic [DW-1:0] d;
    logic          t;
  } ent_t;

  ent_t mq[$];
  ent_t sb[$];
  int m_pkt = 0;
  bit m_pad = 1'b0;
  bit m_padld = 1'b0;
  bit m_ov = 1'b0;
  bit m_ovf = 1'b0;
  bit m_ol = 1'b0;
  logic [DW-1:0] m_od = '0;

  task automatic check(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_tags();
    for (int i = 0; i < mq.size(); i++) begin
      ent_t x;
      x = mq[i];
      x.t = 1'b0;
      mq[i] = x;
    end
  endtask

  task automatic emit(input logic [DW-1:0] d, input logic l);
    ent_t x;
    x.d = d;
    x.t = l;
    sb.push_back(x);
    m_ov = 1'b1;
    m_od = d;
    m_ol = l;
  endtask

  // reference model: a beat queue where a flush tags the newest beat
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        sb.delete();
        m_pkt = 0;
        m_pad = 1'b0;
        m_padld = 1'b0;
        m_ov = 1'b0;
        m_ovf = 1'b0;
        m_ol = 1'b0;
        m_od = '0;
      end else begin
        bit hs, ldok, had, pu, padent, last;
        ent_t e;
        hs = m_ov && c2h_tready;
        ldok = !m_ov || c2h_tready;
        had = (mq.size() > 0);
        pu = rd_valid && (mq.size() < DEPTH);
        if (rd_valid && !pu) m_ovf = 1'b1;
        if (pu) begin
          e.d = rd_data;
          e.t = 1'b0;
          mq.push_back(e);
        end
        padent = 1'b0;
        if (flush) begin
          if (mq.size() > 0) begin
            clear_tags();
            e = mq[mq.size()-1];
            e.t = 1'b1;
            mq[mq.size()-1] = e;
          end else if (!m_pad && m_pkt != 0) begin
            padent = 1'b1;
          end
        end
        if (m_pad) begin
          if (!m_padld && ldok) begin
            emit('0, 1'b1);
            m_padld = 1'b1;
          end else if (m_padld && hs) begin
            m_pad = 1'b0;
            m_padld = 1'b0;
            m_pkt = 0;
            m_ov = 1'b0;
          end else if (hs) begin
            m_ov = 1'b0;
          end
        end else if (ldok && had) begin
          e = mq.pop_front();
          last = e.t || (m_pkt == PKT - 1);
          emit(e.d, last);
          if (last) begin
            m_pkt = 0;
            clear_tags();
          end else begin
            m_pkt++;
          end
        end else if (hs) begin
          m_ov = 1'b0;
        end
        if (padent) m_pad = 1'b1;
      end
    end
  end

  // monitor: compare every cycle, pop the scoreboard on each handshake
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("tvalid", DW'(c2h_tvalid), DW'(m_ov));
        check("space", DW'(buffer_space), DW'(DEPTH - mq.size()));
        check("overflow", DW'(overflow), DW'(m_ovf));
        check("tkeep", DW'(c2h_tkeep), {(DW-DW/8)'(0), {(DW/8){1'b1}}});
        if (m_ov) begin
          check("hold_data", c2h_tdata, m_od);
          check("hold_last", DW'(c2h_tlast), DW'(m_ol));
        end
        if (c2h_tvalid && c2h_tready) begin
          if (sb.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_beat: got %0h want none", c2h_tdata);
          end else begin
            ent_t x;
            x = sb.pop_front();
            check("sb_data", c2h_tdata, x.d);
            check("sb_last", DW'(c2h_tlast), DW'(x.t));
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic cyc(input logic v, input logic [DW-1:0] d,
                     input logic f, input logic r);
    rd_valid = v;
    rd_data = d;
    flush = f;
    c2h_tready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    rd_valid = 1'b0;
    flush = 1'b0;
    c2h_tready = 1'b1;
    while ((sb.size() != 0 || mq.size() != 0 || m_ov || m_pad) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(nm, DW'(n < 400), DW'(1));
  endtask

  logic [DW-1:0] head;

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", DW'(c2h_tvalid), DW'(0));
    check("rst_tlast", DW'(c2h_tlast), DW'(0));
    check("rst_tdata", c2h_tdata, DW'(0));
    check("rst_ovf", DW'(overflow), DW'(0));
    check("rst_space", DW'(buffer_space), DW'(DEPTH));
    rst_n = 1'b1;
    cyc(0, '0, 0, 1);

    // eight back-to-back beats: two packets, two-cycle latency
    cyc(1, DW'(1), 0, 1);
    check("lat_t1", DW'(c2h_tvalid), DW'(0));
    cyc(1, DW'(2), 0, 1);
    check("lat_t2", DW'(c2h_tvalid), DW'(1));
    for (int k = 3; k <= 8; k++) cyc(1, DW'(k), 0, 1);
    drain("drain_seq8");

    // flush with beats still buffered: tlast on beat 3, no pad
    for (int k = 1; k <= 3; k++) cyc(1, DW'(16 + k), 0, 0);
    cyc(0, '0, 0, 0);
    cyc(0, '0, 1, 0);
    drain("drain_flush_buf");
    for (int k = 1; k <= PKT; k++) cyc(1, DW'(32 + k), 0, 1);
    drain("drain_full_pkt");

    // flush after everything left: pad beat closes the packet
    for (int k = 1; k <= 3; k++) cyc(1, DW'(48 + k), 0, 1);
    repeat (3) cyc(0, '0, 0, 1);
    cyc(0, '0, 1, 1);
    drain("drain_pad");
    cyc(0, '0, 1, 1);
    drain("drain_noop_flush");

    // overfill with tready low
    head = rnd_data();
    cyc(1, head, 0, 0);
    for (int k = 1; k < 70; k++) cyc(1, rnd_data(), 0, 0);
    check("full_space", DW'(buffer_space), DW'(0));
    check("full_ovf", DW'(overflow), DW'(1));
    check("full_head", c2h_tdata, head);
    drain("drain_overfill");

    // flush while the head beat is stalled, random tready
    for (int k = 0; k < 5; k++) cyc(1, rnd_data(), 0, 0);
    cyc(0, '0, 1, 0);
    for (int k = 0; k < 30; k++) cyc(0, '0, 0, 1'($urandom_range(0, 1)));
    drain("drain_stall_flush");

    // random traffic
    for (int k = 0; k < 1500; k++)
      cyc($urandom_range(0, 3) != 0, rnd_data(),
          $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    drain("drain_random");

    // reset mid-packet
    for (int k = 0; k < 10; k++) cyc(1, rnd_data(), 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", DW'(c2h_tvalid), DW'(0));
    check("midrst_space", DW'(buffer_space), DW'(DEPTH));
    rd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, '0, 0, 1);
    check("rel_space", DW'(buffer_space), DW'(DEPTH));
    check("rel_ovf", DW'(overflow), DW'(0));
    for (int k = 1; k <= PKT + 1; k++) cyc(1, DW'(96 + k), 0, 1);
    cyc(0, '0, 1, 1);
    drain("drain_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
